hilo_muldiv_ctrl: RTL and testbench

//  Sequences MULT/MULTU/DIV/DIVU/MTHI/MTLO in EXE and owns the architectural HI/LO pair.

---
 rtl/hilo_muldiv_pkg.sv | 36 +++
 rtl/hilo_muldiv_ctrl_div.sv | 69 ++++++
 rtl/hilo_muldiv_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_hilo_muldiv_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_muldiv_pkg.sv
// Shared types for the HI/LO multiply/divide controller: FSM states, counter width
// and the subset of instruction types this block decodes.
package hilo_muldiv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DIV,
        FIX,
        DONE
    } muldiv_state_t;

    localparam int MULDIV_CNT_W = 6;

    typedef enum logic [6:0] {
        OP_NOP   = 7'd0,
        OP_ADD   = 7'd1,
        OP_MULT  = 7'd20,
        OP_MULTU = 7'd21,
        OP_DIV   = 7'd22,
        OP_DIVU  = 7'd23,
        OP_MFHI  = 7'd24,
        OP_MFLO  = 7'd25,
        OP_MTHI  = 7'd26,
        OP_MTLO  = 7'd27
    } instr_type_t;

    function automatic logic is_mul_op(input logic [6:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

    function automatic logic is_div_op(input logic [6:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_div.sv
// Iterative restoring divider on unsigned 32-bit magnitudes, one quotient bit per step.
// Sign handling and sequencing live in the controller.
module div_radix2_core
    import hilo_muldiv_pkg::*;
#(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        done
);

    logic [31:0]             quo_q, quo_d;
    logic [31:0]             rem_q, rem_d;
    logic [31:0]             dvs_q, dvs_d;
    logic [MULDIV_CNT_W-1:0] iter_q, iter_d;
    logic [32:0]             rem_sh;
    logic [32:0]             diff;

    assign done      = (iter_q == MULDIV_CNT_W'(ITER));
    assign quotient  = quo_q;
    assign remainder = rem_q;

    // Bit 32 of the trial difference is the borrow: set means restore.
    always_comb begin
        quo_d  = quo_q;
        rem_d  = rem_q;
        dvs_d  = dvs_q;
        iter_d = iter_q;
        rem_sh = {rem_q, quo_q[31]};
        diff   = rem_sh - {1'b0, dvs_q};
        if (start) begin
            quo_d  = dividend;
            rem_d  = '0;
            dvs_d  = divisor;
            iter_d = '0;
        end else if (step && !done) begin
            if (!diff[32]) begin
                rem_d = diff[31:0];
                quo_d = {quo_q[30:0], 1'b1};
            end else begin
                rem_d = rem_sh[31:0];
                quo_d = {quo_q[30:0], 1'b0};
            end
            iter_d = iter_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            iter_q <= '0;
        end else begin
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
            iter_q <= iter_d;
        end
    end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// EXE-stage HI/LO owner: sequences MULT/MULTU/DIV/DIVU/MTHI/MTLO, stalls the pipe
// while multi-cycle ops run and commits HI/LO only on an unflushed completion.
module hilo_muldiv_ctrl
    import hilo_muldiv_pkg::*;
#(
    parameter int MUL_LAT  = 2,
    parameter int DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  EXE_Op,
    input  logic        EXE_Valid,
    input  logic [31:0] EXE_rs,
    input  logic [31:0] EXE_rt,
    input  logic        EXE_Flush,
    output logic        EXE_Stall,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        Busy
);

    muldiv_state_t           state_q, state_d;
    logic [MULDIV_CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]             hi_q, hi_d, lo_q, lo_d;
    logic [63:0]             mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [63:0]             prod_q [MUL_LAT];
    logic [63:0]             prod_d [MUL_LAT];
    logic [31:0]             mag_a_q, mag_a_d, mag_b_q, mag_b_d;
    logic                    neg_a_q, neg_a_d, neg_b_q, neg_b_d;
    logic                    div0_q, div0_d;
    logic                    is_mul_q, is_mul_d;
    logic                    div_started_q, div_started_d;
    logic [63:0]             res_q, res_d;

    logic        accept, op_mul, op_div, op_signed;
    logic        core_start, core_step, core_done;
    logic [31:0] core_quo, core_rem, quo_fix, rem_fix;

    assign op_mul    = is_mul_op(EXE_Op);
    assign op_div    = is_div_op(EXE_Op);
    assign op_signed = (EXE_Op == OP_MULT) || (EXE_Op == OP_DIV);
    assign accept    = (state_q == IDLE) && EXE_Valid && !EXE_Flush;

    assign EXE_Stall = rst && ((accept && (op_mul || op_div)) ||
                               (state_q == MUL) || (state_q == DIV) || (state_q == FIX));
    assign Busy      = (state_q != IDLE);
    assign HI        = hi_q;
    assign LO        = lo_q;

    // The first DIV cycle loads the core; the counted iterations follow.
    assign core_start = (state_q == DIV) && !div_started_q;
    assign core_step  = (state_q == DIV) && div_started_q;

    div_radix2_core #(.ITER(DIV_ITER)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (core_start),
        .step      (core_step),
        .dividend  (mag_a_q),
        .divisor   (mag_b_q),
        .quotient  (core_quo),
        .remainder (core_rem),
        .done      (core_done)
    );

    // neg_b is only ever set for signed divides, so DIVU passes through untouched.
    assign quo_fix = (neg_a_q ^ neg_b_q) ? (~core_quo + 32'd1) : core_quo;
    assign rem_fix = neg_a_q ? (~core_rem + 32'd1) : core_rem;

    always_comb begin
        prod_d[0] = mul_a_q * mul_b_q;
        for (int i = 1; i < MUL_LAT; i++) begin
            prod_d[i] = prod_q[i-1];
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        hi_d          = hi_q;
        lo_d          = lo_q;
        mul_a_d       = mul_a_q;
        mul_b_d       = mul_b_q;
        mag_a_d       = mag_a_q;
        mag_b_d       = mag_b_q;
        neg_a_d       = neg_a_q;
        neg_b_d       = neg_b_q;
        div0_d        = div0_q;
        is_mul_d      = is_mul_q;
        div_started_d = div_started_q;
        res_d         = res_q;

        if (EXE_Flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (op_mul) begin
                            mul_a_d  = op_signed ? {{32{EXE_rs[31]}}, EXE_rs} : {32'd0, EXE_rs};
                            mul_b_d  = op_signed ? {{32{EXE_rt[31]}}, EXE_rt} : {32'd0, EXE_rt};
                            is_mul_d = 1'b1;
                            cnt_d    = MULDIV_CNT_W'(MUL_LAT - 1);
                            state_d  = MUL;
                        end else if (op_div) begin
                            neg_a_d       = op_signed && EXE_rs[31];
                            neg_b_d       = op_signed && EXE_rt[31];
                            mag_a_d       = neg_a_d ? (~EXE_rs + 32'd1) : EXE_rs;
                            mag_b_d       = neg_b_d ? (~EXE_rt + 32'd1) : EXE_rt;
                            div0_d        = (EXE_rt == 32'd0);
                            res_d         = {EXE_rs, 32'hFFFF_FFFF};
                            is_mul_d      = 1'b0;
                            div_started_d = 1'b0;
                            cnt_d         = MULDIV_CNT_W'(DIV_ITER - 1);
                            state_d       = DIV;
                        end else if (EXE_Op == OP_MTHI) begin
                            hi_d = EXE_rs;
                        end else if (EXE_Op == OP_MTLO) begin
                            lo_d = EXE_rs;
                        end
                    end
                end
                MUL: begin
                    if (cnt_q == '0) state_d = DONE;
                    else             cnt_d   = cnt_q - 1'b1;
                end
                DIV: begin
                    if (!div_started_q) begin
                        div_started_d = 1'b1;
                    end else if (cnt_q == '0) begin
                        state_d = div0_q ? DONE : FIX;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                FIX: begin
                    if (core_done) res_d = {rem_fix, quo_fix};
                    state_d = DONE;
                end
                DONE: begin
                    {hi_d, lo_d} = is_mul_q ? prod_q[MUL_LAT-1] : res_q;
                    state_d      = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            hi_q          <= '0;
            lo_q          <= '0;
            mul_a_q       <= '0;
            mul_b_q       <= '0;
            mag_a_q       <= '0;
            mag_b_q       <= '0;
            neg_a_q       <= 1'b0;
            neg_b_q       <= 1'b0;
            div0_q        <= 1'b0;
            is_mul_q      <= 1'b0;
            div_started_q <= 1'b0;
            res_q         <= '0;
            for (int i = 0; i < MUL_LAT; i++) prod_q[i] <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            hi_q          <= hi_d;
            lo_q          <= lo_d;
            mul_a_q       <= mul_a_d;
            mul_b_q       <= mul_b_d;
            mag_a_q       <= mag_a_d;
            mag_b_q       <= mag_b_d;
            neg_a_q       <= neg_a_d;
            neg_b_q       <= neg_b_d;
            div0_q        <= div0_d;
            is_mul_q      <= is_mul_d;
            div_started_q <= div_started_d;
            res_q         <= res_d;
            for (int i = 0; i < MUL_LAT; i++) prod_q[i] <= prod_d[i];
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Self-checking bench for hilo_muldiv_ctrl: directed corner cases, flushes, resets and
// randomized op streams against an arithmetic HI/LO model.
module tb_hilo_muldiv_ctrl;
    import hilo_muldiv_pkg::*;

    localparam int MUL_LAT  = 2;
    localparam int DIV_ITER = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  EXE_Op;
    logic        EXE_Valid;
    logic [31:0] EXE_rs, EXE_rt;
    logic        EXE_Flush;
    logic        EXE_Stall;
    logic [31:0] HI, LO;
    logic        Busy;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_hi   = '0;
    logic [31:0] exp_lo   = '0;

    hilo_muldiv_ctrl #(.MUL_LAT(MUL_LAT), .DIV_ITER(DIV_ITER)) dut (
        .clk       (clk),
        .rst       (rst),
        .EXE_Op    (EXE_Op),
        .EXE_Valid (EXE_Valid),
        .EXE_rs    (EXE_rs),
        .EXE_rt    (EXE_rt),
        .EXE_Flush (EXE_Flush),
        .EXE_Stall (EXE_Stall),
        .HI        (HI),
        .LO        (LO),
        .Busy      (Busy)
    );

    always #5 clk = ~clk;

    // Architectural effect of one completed op, from plain arithmetic.
    function automatic void model(input logic [6:0] op, input logic [31:0] rs, input logic [31:0] rt);
        longint          sa, sb, sq, sr;
        longint unsigned up;
        logic [63:0]     p;
        case (op)
            OP_MULT: begin
                sa = longint'($signed(rs));
                sb = longint'($signed(rt));
                p  = 64'(sa * sb);
                exp_hi = p[63:32];
                exp_lo = p[31:0];
            end
            OP_MULTU: begin
                up = {32'd0, rs} * {32'd0, rt};
                p  = up;
                exp_hi = p[63:32];
                exp_lo = p[31:0];
            end
            OP_DIV, OP_DIVU: begin
                if (rt == 32'd0) begin
                    exp_lo = 32'hFFFF_FFFF;
                    exp_hi = rs;
                end else if (op == OP_DIV) begin
                    sa = longint'($signed(rs));
                    sb = longint'($signed(rt));
                    sq = sa / sb;
                    sr = sa % sb;
                    exp_lo = sq[31:0];
                    exp_hi = sr[31:0];
                end else begin
                    exp_lo = rs / rt;
                    exp_hi = rs % rt;
                end
            end
            OP_MTHI: exp_hi = rs;
            OP_MTLO: exp_lo = rs;
            default: ;
        endcase
    endfunction

    // Cycles EXE must be held from the accept cycle onward; -1 where not pinned down.
    function automatic int exp_stall(input logic [6:0] op, input logic [31:0] rt);
        if (op == OP_MULT || op == OP_MULTU) return MUL_LAT + 1;
        if (op == OP_DIV || op == OP_DIVU) return (rt == 32'd0) ? -1 : DIV_ITER + 3;
        return 0;
    endfunction

    task automatic run_op(input logic [6:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          output int stalls);
        @(negedge clk);
        EXE_Op    = op;
        EXE_Valid = 1'b1;
        EXE_rs    = rs;
        EXE_rt    = rt;
        stalls    = 0;
        #1;
        while (EXE_Stall === 1'b1 && stalls < 200) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        EXE_Valid = 1'b0;
        EXE_Op    = OP_NOP;
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        EXE_Op    = OP_MULT;
        EXE_Valid = 1'b1;
        EXE_rs    = 32'h1234_5678;
        EXE_rt    = 32'h9;
        EXE_Flush = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (HI !== 32'd0) begin failures++; $display("[TB] FAIL reset_hi got %h want 00000000", HI); end
        checks++; if (LO !== 32'd0) begin failures++; $display("[TB] FAIL reset_lo got %h want 00000000", LO); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got %b want 0", Busy); end
        checks++; if (EXE_Stall !== 1'b0) begin failures++; $display("[TB] FAIL reset_stall got %b want 0", EXE_Stall); end
        EXE_Valid = 1'b0;
        EXE_Op    = OP_NOP;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [6:0]  ops [8] = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_DIV, OP_DIVU, OP_DIV, OP_DIV};
        logic [31:0] rss [8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'h64,
                                 32'h8000_0000, 32'h64, 32'h7, 32'hFFFF_FFF9};
        logic [31:0] rts [8] = '{32'h2, 32'h2, 32'h2, 32'h0,
                                 32'hFFFF_FFFF, 32'h7, 32'hFFFF_FFFE, 32'h0};
        int stalls, es;
        for (int i = 0; i < 8; i++) begin
            run_op(ops[i], rss[i], rts[i], stalls);
            model(ops[i], rss[i], rts[i]);
            es = exp_stall(ops[i], rts[i]);
            checks++; if (HI !== exp_hi) begin failures++; $display("[TB] FAIL directed_hi[%0d] got %h want %h", i, HI, exp_hi); end
            checks++; if (LO !== exp_lo) begin failures++; $display("[TB] FAIL directed_lo[%0d] got %h want %h", i, LO, exp_lo); end
            if (es >= 0) begin
                checks++; if (stalls != es) begin failures++; $display("[TB] FAIL directed_stall[%0d] got %0d want %0d", i, stalls, es); end
            end else begin
                checks++; if (stalls >= 200) begin failures++; $display("[TB] FAIL directed_timeout[%0d] got %0d want <200", i, stalls); end
            end
        end
    endtask

    task automatic test_mthi_mtlo();
        int stalls;
        run_op(OP_MTHI, 32'h0000_1234, 32'h0, stalls);
        model(OP_MTHI, 32'h0000_1234, 32'h0);
        run_op(OP_MFHI, 32'h0, 32'h0, stalls);
        checks++; if (HI !== 32'h0000_1234) begin failures++; $display("[TB] FAIL mthi_hi got %h want 00001234", HI); end
        checks++; if (stalls != 0) begin failures++; $display("[TB] FAIL mthi_stall got %0d want 0", stalls); end
        run_op(OP_MTLO, 32'hCAFE_F00D, 32'h0, stalls);
        model(OP_MTLO, 32'hCAFE_F00D, 32'h0);
        checks++; if (LO !== exp_lo) begin failures++; $display("[TB] FAIL mtlo_lo got %h want %h", LO, exp_lo); end
        checks++; if (HI !== exp_hi) begin failures++; $display("[TB] FAIL mtlo_hi got %h want %h", HI, exp_hi); end
    endtask

    task automatic test_flush();
        int n;
        // Flush while a divide is running: abandoned, nothing written.
        @(negedge clk);
        EXE_Op = OP_DIV; EXE_Valid = 1'b1; EXE_rs = 32'hFFFF_FFF9; EXE_rt = 32'h2;
        repeat (10) @(negedge clk);
        #1;
        checks++; if (Busy !== 1'b1) begin failures++; $display("[TB] FAIL flush_busy_before got %b want 1", Busy); end
        EXE_Flush = 1'b1;
        @(posedge clk); #1;
        EXE_Flush = 1'b0; EXE_Valid = 1'b0; EXE_Op = OP_NOP;
        #1;
        checks++; if (Busy !== 1'b0) begin failures++; $display("[TB] FAIL flush_div_busy got %b want 0", Busy); end
        checks++; if (EXE_Stall !== 1'b0) begin failures++; $display("[TB] FAIL flush_div_stall got %b want 0", EXE_Stall); end
        checks++; if (HI !== exp_hi || LO !== exp_lo) begin failures++; $display("[TB] FAIL flush_div_hilo got %h_%h want %h_%h", HI, LO, exp_hi, exp_lo); end

        // Flush in the accept cycle: MTHI suppressed, MULT never starts.
        @(negedge clk);
        EXE_Op = OP_MTHI; EXE_Valid = 1'b1; EXE_rs = 32'hDEAD_BEEF; EXE_Flush = 1'b1;
        @(posedge clk); #1;
        checks++; if (HI !== exp_hi) begin failures++; $display("[TB] FAIL flush_mthi got %h want %h", HI, exp_hi); end
        @(negedge clk);
        EXE_Op = OP_MULT; EXE_rs = 32'h7; EXE_rt = 32'h9;
        #1;
        checks++; if (EXE_Stall !== 1'b0) begin failures++; $display("[TB] FAIL flush_accept_stall got %b want 0", EXE_Stall); end
        @(posedge clk); #1;
        EXE_Flush = 1'b0; EXE_Valid = 1'b0; EXE_Op = OP_NOP;
        checks++; if (Busy !== 1'b0) begin failures++; $display("[TB] FAIL flush_accept_busy got %b want 0", Busy); end

        // Flush in the completion cycle: the write is dropped.
        @(negedge clk);
        EXE_Op = OP_MULTU; EXE_Valid = 1'b1; EXE_rs = 32'hFFFF_FFFF; EXE_rt = 32'hFFFF_FFFF;
        n = 0;
        #1;
        while (EXE_Stall === 1'b1 && n < 200) begin n++; @(negedge clk); #1; end
        EXE_Flush = 1'b1;
        @(posedge clk); #1;
        EXE_Flush = 1'b0; EXE_Valid = 1'b0; EXE_Op = OP_NOP;
        checks++; if (n != MUL_LAT + 1) begin failures++; $display("[TB] FAIL flush_done_stall got %0d want %0d", n, MUL_LAT + 1); end
        checks++; if (HI !== exp_hi || LO !== exp_lo) begin failures++; $display("[TB] FAIL flush_done_hilo got %h_%h want %h_%h", HI, LO, exp_hi, exp_lo); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("[TB] FAIL flush_done_busy got %b want 0", Busy); end
    endtask

    task automatic test_reset_mid_div();
        int stalls;
        run_op(OP_MTHI, 32'h5555_AAAA, 32'h0, stalls);
        model(OP_MTHI, 32'h5555_AAAA, 32'h0);
        checks++; if (HI !== exp_hi) begin failures++; $display("[TB] FAIL pre_reset_hi got %h want %h", HI, exp_hi); end
        @(negedge clk);
        EXE_Op = OP_DIV; EXE_Valid = 1'b1; EXE_rs = 32'd100; EXE_rt = 32'd3;
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        exp_hi = '0;
        exp_lo = '0;
        checks++; if (HI !== 32'd0 || LO !== 32'd0) begin failures++; $display("[TB] FAIL rst_mid_hilo got %h_%h want 0_0", HI, LO); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_busy got %b want 0", Busy); end
        checks++; if (EXE_Stall !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_stall got %b want 0", EXE_Stall); end
        EXE_Valid = 1'b0;
        EXE_Op    = OP_NOP;
        @(negedge clk);
        rst = 1'b1;
    endtask

    function automatic logic [31:0] pick_value();
        case ($urandom_range(0, 5))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'($urandom_range(0, 20));
            3:       return 32'(0) - 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        logic [6:0]  op_tab [7] = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO, OP_ADD};
        logic [6:0]  op;
        logic [31:0] rs, rt;
        int          stalls, es;
        for (int i = 0; i < 40; i++) begin
            op = op_tab[$urandom_range(0, 6)];
            rs = pick_value();
            rt = ($urandom_range(0, 7) == 0) ? 32'd0 : pick_value();
            run_op(op, rs, rt, stalls);
            model(op, rs, rt);
            es = exp_stall(op, rt);
            checks++; if (HI !== exp_hi || LO !== exp_lo) begin
                failures++;
                $display("[TB] FAIL random_hilo[%0d] op=%0d rs=%h rt=%h got %h_%h want %h_%h", i, op, rs, rt, HI, LO, exp_hi, exp_lo);
            end
            if (es >= 0) begin
                checks++; if (stalls != es) begin failures++; $display("[TB] FAIL random_stall[%0d] op=%0d got %0d want %0d", i, op, stalls, es); end
            end
        end
    endtask

    initial begin
        EXE_Flush = 1'b0;
        test_reset();
        test_directed();
        test_mthi_mtlo();
        test_flush();
        test_reset_mid_div();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
